// File: rtl/arith_interval_update.sv
// arith_interval_update
// Upstream core of an arithmetic encoder. Accepts one 3-bit symbol per
// handshake and narrows the [low, high] interval using a fixed cumulative
// count table. Then performs E1/E2/E3 rescaling, streams resolved code bits
// and emits pending E3 bits. On the last symbol of a message it hands the
// final low word and the outstanding E3 count to the code-ending stage.
//
// Ports
//   sys_clk       in   1     clock, rising edge
//   sys_reset     in   1     asynchronous active-high reset
//   sym_valid     in   1     symbol offered
//   symbol_in     in   3     symbol index 0..5 (6/7 are invalid)
//   sym_last      in   1     offered symbol closes the message
//   sym_ready     out  1     block can accept a symbol
//   bit_valid     out  1     bit_out valid this cycle (never back-pressured)
//   bit_out       out  1     code bit
//   end_valid     out  1     one-cycle pulse, end_low/end_e3_count valid
//   end_low       out  WORD  final low register
//   end_e3_count  out  7     outstanding E3 count at termination
//   err           out  1     sticky: invalid symbol or E3 counter overflow
module arith_interval_update #(
  parameter int          WORD  = 9,
  parameter int          TOTAL = 96,
  parameter logic [48:0] CUM   = {7'd96, 7'd92, 7'd86, 7'd76, 7'd60, 7'd40, 7'd0}
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic            sym_valid,
  input  logic [2:0]      symbol_in,
  input  logic            sym_last,
  output logic            sym_ready,
  output logic            bit_valid,
  output logic            bit_out,
  output logic            end_valid,
  output logic [WORD-1:0] end_low,
  output logic [6:0]      end_e3_count,
  output logic            err
);

  localparam int              PROD_W    = 16;
  localparam logic [WORD-1:0] HIGH_INIT = '1;
  localparam logic [6:0]      E3_MAX    = 7'd127;
  localparam logic [2:0]      SYM_MAX   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SCALE  = 3'd2,
    ST_PEND   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r;
  logic [WORD-1:0] low_r;
  logic [WORD-1:0] high_r;
  logic [6:0]      e3_r;
  logic            pend_bit_r;
  logic            last_r;
  logic [2:0]      sym_r;

  logic [WORD:0]   range_s;
  logic [PROD_W-1:0] prod_lo_s;
  logic [PROD_W-1:0] prod_hi_s;
  logic [WORD-1:0] low_upd_s;
  logic [WORD-1:0] high_upd_s;
  logic            e1_s;
  logic            e2_s;
  logic            e3_s;
  logic [WORD-1:0] low_shift_s;
  logic [WORD-1:0] high_shift_s;
  logic [WORD-1:0] low_e3_s;
  logic [WORD-1:0] high_e3_s;

  // Cumulative count for symbol boundary k (k = 0..6).
  function automatic logic [6:0] cum_at(input logic [2:0] k);
    logic [6:0] v;
    v = CUM[7*k +: 7];
    return v;
  endfunction

  // Interval narrowing and rescale classification of the current interval.
  always_comb begin
    range_s    = {1'b0, high_r} - {1'b0, low_r} + {{WORD{1'b0}}, 1'b1};
    prod_lo_s  = PROD_W'(range_s) * PROD_W'(cum_at(sym_r));
    prod_hi_s  = PROD_W'(range_s) * PROD_W'(cum_at(sym_r + 3'd1));
    low_upd_s  = low_r + WORD'(prod_lo_s / PROD_W'(TOTAL));
    high_upd_s = low_r + WORD'(prod_hi_s / PROD_W'(TOTAL)) - {{(WORD-1){1'b0}}, 1'b1};

    e1_s = ~low_r[WORD-1] & ~high_r[WORD-1];
    e2_s =  low_r[WORD-1] &  high_r[WORD-1];
    e3_s = (low_r[WORD-1:WORD-2] == 2'b01) & (high_r[WORD-1:WORD-2] == 2'b10);

    // E1/E2: shift out the resolved MSB, shift a 1 into high.
    low_shift_s  = {low_r[WORD-2:0], 1'b0};
    high_shift_s = {high_r[WORD-2:0], 1'b1};
    // E3: subtracting a quarter from 01.../10... clears/sets the second MSB,
    // so the doubled result is a shift that keeps only the low WORD-2 bits.
    low_e3_s  = {1'b0, low_r[WORD-3:0], 1'b0};
    high_e3_s = {1'b1, high_r[WORD-3:0], 1'b1};
  end

  // Control FSM, interval state and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_r      <= ST_IDLE;
      low_r        <= '0;
      high_r       <= HIGH_INIT;
      e3_r         <= 7'd0;
      pend_bit_r   <= 1'b0;
      last_r       <= 1'b0;
      sym_r        <= 3'd0;
      sym_ready    <= 1'b0;
      bit_valid    <= 1'b0;
      bit_out      <= 1'b0;
      end_valid    <= 1'b0;
      end_low      <= '0;
      end_e3_count <= 7'd0;
      err          <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      end_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sym_valid && sym_ready) begin
            if (symbol_in <= SYM_MAX) begin
              sym_r     <= symbol_in;
              last_r    <= sym_last;
              sym_ready <= 1'b0;
              state_r   <= ST_UPDATE;
            end else begin
              // Invalid symbol is dropped; stay ready for the next one.
              err       <= 1'b1;
              sym_ready <= 1'b1;
            end
          end else begin
            sym_ready <= 1'b1;
          end
        end

        ST_UPDATE: begin
          low_r   <= low_upd_s;
          high_r  <= high_upd_s;
          state_r <= ST_SCALE;
        end

        ST_SCALE: begin
          if (e1_s || e2_s) begin
            bit_valid  <= 1'b1;
            bit_out    <= e2_s;
            // Pending E3 bits are the complement of the bit just emitted.
            pend_bit_r <= e1_s;
            low_r      <= low_shift_s;
            high_r     <= high_shift_s;
            if (e3_r != 7'd0) begin
              state_r <= ST_PEND;
            end else begin
              state_r <= ST_SCALE;
            end
          end else if (e3_s) begin
            low_r  <= low_e3_s;
            high_r <= high_e3_s;
            if (e3_r == E3_MAX) begin
              err <= 1'b1;
            end else begin
              e3_r <= e3_r + 7'd1;
            end
          end else if (last_r) begin
            end_valid    <= 1'b1;
            end_low      <= low_r;
            end_e3_count <= e3_r;
            state_r      <= ST_DONE;
          end else begin
            sym_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end

        ST_PEND: begin
          bit_valid <= 1'b1;
          bit_out   <= pend_bit_r;
          e3_r      <= e3_r - 7'd1;
          if (e3_r <= 7'd1) begin
            state_r <= ST_SCALE;
          end else begin
            state_r <= ST_PEND;
          end
        end

        ST_DONE: begin
          low_r     <= '0;
          high_r    <= HIGH_INIT;
          e3_r      <= 7'd0;
          sym_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end

        default: begin
          sym_ready <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_interval_update.sv
// Self-checking bench for arith_interval_update: directed messages with a
// scoreboard of expected code bits and end words, popped as the DUT emits them.
module tb_arith_interval_update;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       sym_valid;
  logic [2:0] symbol_in;
  logic       sym_last;
  logic       sym_ready;
  logic       bit_valid;
  logic       bit_out;
  logic       end_valid;
  logic [8:0] end_low;
  logic [6:0] end_e3_count;
  logic       err;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  logic       exp_bit_q[$];
  logic [8:0] exp_low_q[$];
  logic [6:0] exp_e3_q[$];
  int         bit_n_q[$];
  int         end_n_q[$];

  arith_interval_update dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .sym_valid    (sym_valid),
    .symbol_in    (symbol_in),
    .sym_last     (sym_last),
    .sym_ready    (sym_ready),
    .bit_valid    (bit_valid),
    .bit_out      (bit_out),
    .end_valid    (end_valid),
    .end_low      (end_low),
    .end_e3_count (end_e3_count),
    .err          (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push n expected bits, first-emitted bit is bits[n-1].
  task automatic push_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bit_q.push_back(bits[i]);
  endtask

  task automatic push_end(input logic [8:0] lo, input logic [6:0] e3);
    exp_low_q.push_back(lo);
    exp_e3_q.push_back(e3);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (sym_ready) break;
      @(posedge sys_clk); #1;
    end
    chk(tag, 32'(sym_ready), 1);
  endtask

  // Offer one symbol; acc_n is the negedge index just after the accepting edge.
  task automatic send(input logic [2:0] s, input logic last, output int acc_n);
    wait_ready("ready_before_send");
    symbol_in = s;
    sym_last  = last;
    sym_valid = 1'b1;
    acc_n     = ncyc + 2;
    @(posedge sys_clk); #1;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_bits_drained"}, exp_bit_q.size(), 0);
    chk({tag, "_ends_drained"}, exp_low_q.size(), 0);
  endtask

  // Output monitor: sampled on the falling edge, pops the scoreboard.
  initial begin
    forever begin
      @(negedge sys_clk);
      ncyc++;
      if (!sys_reset) begin
        chk("bit_end_exclusive", 32'(bit_valid & end_valid), 0);
        if (bit_valid) begin
          bit_n_q.push_back(ncyc);
          if (exp_bit_q.size() == 0) chk("unexpected_bit", exp_bit_q.size(), 1);
          else chk("bit_out", 32'(bit_out), 32'(exp_bit_q.pop_front()));
        end
        if (end_valid) begin
          end_n_q.push_back(ncyc);
          if (exp_low_q.size() == 0) chk("unexpected_end", exp_low_q.size(), 1);
          else begin
            chk("end_low", 32'(end_low), 32'(exp_low_q.pop_front()));
            chk("end_e3_count", 32'(end_e3_count), 32'(exp_e3_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    sys_reset = 1'b1;
    sym_valid = 1'b0;
    symbol_in = 3'd0;
    sym_last  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_sym_ready", 32'(sym_ready), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_end_valid", 32'(end_valid), 0);
    chk("rst_end_low", 32'(end_low), 0);
    chk("rst_end_e3", 32'(end_e3_count), 0);
    chk("rst_err", 32'(err), 0);
    sys_reset = 1'b0;
    @(posedge sys_clk); #1;
    chk("ready_after_reset", 32'(sym_ready), 1);

    // Symbol 0, last: one E1 bit 0, end low 0 / e3 0.
    bit_n_q.delete(); end_n_q.delete();
    push_bits(8'b0, 1); push_end(9'd0, 7'd0);
    send(3'd0, 1'b1, acc);
    chk("s0_ready_drop", 32'(sym_ready), 0);
    wait_ready("s0_ready_back");
    drained("s0");
    chk("s0_bit_latency", bit_n_q[0] - acc, 2);
    chk("s0_end_latency", end_n_q[0] - acc, 3);

    // Symbol 5, last: four consecutive E2 bits, end low 160.
    bit_n_q.delete(); end_n_q.delete();
    push_bits(8'b1111, 4); push_end(9'd160, 7'd0);
    send(3'd5, 1'b1, acc);
    wait_ready("s5_ready_back");
    drained("s5");
    chk("s5_bit_count", bit_n_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("s5_bit_cycle", bit_n_q[i] - acc, 2 + i);
    chk("s5_end_latency", end_n_q[0] - acc, 6);

    // Symbol 2, last: E2 bit 1 then E3, end e3 count 1.
    bit_n_q.delete(); end_n_q.delete();
    push_bits(8'b1, 1); push_end(9'd0, 7'd1);
    send(3'd2, 1'b1, acc);
    wait_ready("s2_ready_back");
    drained("s2");
    chk("s2_end_latency", end_n_q[0] - acc, 4);

    // Symbol 2 then symbol 0 last: bits 1, 0, 1 with pending bit right after E1.
    bit_n_q.delete(); end_n_q.delete();
    push_bits(8'b1, 1);
    send(3'd2, 1'b0, acc);
    wait_ready("s20_mid_ready");
    chk("s20_no_end_mid", end_n_q.size(), 0);
    bit_n_q.delete();
    push_bits(8'b01, 2); push_end(9'd0, 7'd0);
    send(3'd0, 1'b1, acc);
    wait_ready("s20_ready_back");
    drained("s20");
    chk("s20_pend_follows", bit_n_q[1] - bit_n_q[0], 1);

    // Invalid symbol 7: err set, dropped, still ready, no bits.
    bit_n_q.delete(); end_n_q.delete();
    wait_ready("inv_ready_before");
    symbol_in = 3'd7;
    sym_valid = 1'b1;
    @(posedge sys_clk); #1;
    sym_valid = 1'b0;
    chk("inv_err", 32'(err), 1);
    chk("inv_ready", 32'(sym_ready), 1);
    repeat (4) @(posedge sys_clk);
    #1;
    chk("inv_ready_hold", 32'(sym_ready), 1);
    chk("inv_err_sticky", 32'(err), 1);
    chk("inv_no_bits", bit_n_q.size(), 0);

    // Reset during SCALE: message discarded, outputs and err cleared.
    send(3'd5, 1'b1, acc);
    @(posedge sys_clk); #1;
    sys_reset = 1'b1;
    @(posedge sys_clk); #1;
    chk("mid_rst_sym_ready", 32'(sym_ready), 0);
    chk("mid_rst_bit_valid", 32'(bit_valid), 0);
    chk("mid_rst_bit_out", 32'(bit_out), 0);
    chk("mid_rst_end_valid", 32'(end_valid), 0);
    chk("mid_rst_end_low", 32'(end_low), 0);
    chk("mid_rst_end_e3", 32'(end_e3_count), 0);
    chk("mid_rst_err", 32'(err), 0);
    sys_reset = 1'b0;
    @(posedge sys_clk); #1;
    chk("mid_rst_ready", 32'(sym_ready), 1);
    chk("mid_rst_no_bits", bit_n_q.size(), 0);
    chk("mid_rst_no_end", end_n_q.size(), 0);

    // Back-to-back single-symbol-5 messages must repeat exactly.
    for (int m = 0; m < 2; m++) begin
      bit_n_q.delete(); end_n_q.delete();
      push_bits(8'b1111, 4); push_end(9'd160, 7'd0);
      send(3'd5, 1'b1, acc);
      wait_ready("b2b_ready_back");
      drained("b2b");
      chk("b2b_bit_count", bit_n_q.size(), 4);
      chk("b2b_first_bit", bit_n_q[0] - acc, 2);
      chk("b2b_end_latency", end_n_q[0] - acc, 6);
    end
    chk("final_err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
